// File: rtl/div_iter_pkg.sv
// Shared defines for the integer execution units: ALU control codes plus
// the state encoding and iteration count of the iterative divider.
package div_iter_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_DIV  = 4'd10,
        ALU_DIVU = 4'd11
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITERS);
    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_ITERS - 1);

endpackage

// File: rtl/div_iter.sv
// Iterative 32-bit radix-2 restoring divider (signed/unsigned), one quotient
// bit per cycle; result is {remainder, quotient}.
module div_iter
    import div_iter_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_div,
    input  logic        signed_div,
    input  logic [31:0] div_srca,
    input  logic [31:0] div_srcb,
    output logic [63:0] div_result,
    output logic        div_ready
);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]          work_q, work_d;
    logic [31:0]          divisor_q, divisor_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [63:0]          result_q, result_d;

    logic [31:0] abs_a, abs_b;
    logic [32:0] step_diff;
    logic [63:0] step_work;
    logic [31:0] quo_mag, rem_mag;

    // Operand magnitudes and the single shared 33-bit subtractor.
    always_comb begin
        abs_a = (signed_div && div_srca[31]) ? (32'd0 - div_srca) : div_srca;
        abs_b = (signed_div && div_srcb[31]) ? (32'd0 - div_srcb) : div_srcb;
        // Upper 33 bits of the working register after the left shift.
        step_diff = work_q[63:31] - {1'b0, divisor_q};
        step_work = step_diff[32] ? {work_q[62:0], 1'b0}
                                  : {step_diff[31:0], work_q[30:0], 1'b1};
        quo_mag   = step_work[31:0];
        rem_mag   = step_work[63:32];
    end

    // NOTE: every signal written here gets its hold value first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        case (state_q)
            DIV_IDLE: begin
                if (start_div) begin
                    neg_quo_d = (div_srca[31] ^ div_srcb[31]) & signed_div;
                    neg_rem_d = div_srca[31] & signed_div;
                    work_d    = {32'd0, abs_a};
                    divisor_d = abs_b;
                    cnt_d     = '0;
                    if (div_srcb == 32'd0) begin
                        state_d  = DIV_DONE;
                        result_d = {div_srca, 32'hFFFF_FFFF};
                    end else begin
                        state_d  = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                // Dropping start abandons the operation and keeps the old result.
                if (!start_div) begin
                    state_d = DIV_IDLE;
                end else begin
                    work_d = step_work;
                    cnt_d  = cnt_q + DIV_CNT_W'(1);
                    if (cnt_q == DIV_LAST) begin
                        state_d  = DIV_DONE;
                        result_d = {neg_rem_q ? (32'd0 - rem_mag) : rem_mag,
                                    neg_quo_q ? (32'd0 - quo_mag) : quo_mag};
                    end
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    // NOTE: reset is synchronous (sampled only at the clock edge) and, like all
    // state updates here, uses non-blocking assignments so every flop sees the
    // pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign div_ready  = (state_q == DIV_DONE);
    assign div_result = result_q;

endmodule
